sseg_capture: RTL and testbench

SSEG_CAPTURE -- requirements
Module: sseg_capture

---
 rtl/sseg_capture_pkg.sv | 38 +++
 rtl/sseg_pattern_decode.sv | 22 ++
 rtl/sseg_capture.sv | 130 +++++++++++++
 tb/tb_sseg_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_capture_pkg.sv
// Shared constants for the seven-segment display capture block: digit count,
// segment bit positions and the active-high segment pattern of each hex digit.
package sseg_capture_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum int unsigned {
        SEG_A  = 0,
        SEG_B  = 1,
        SEG_C  = 2,
        SEG_D  = 3,
        SEG_E  = 4,
        SEG_F  = 5,
        SEG_G  = 6,
        SEG_DP = 7
    } seg_idx_e;

    // Lit segments {g,f,e,d,c,b,a} for digits 0..F; entry i decodes to nibble i
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71,  // F  aefg
        7'h79,  // E  adefg
        7'h5E,  // d  bcdeg
        7'h39,  // C  adef
        7'h7C,  // b  cdefg
        7'h77,  // A  abcefg
        7'h6F,  // 9  abcdfg
        7'h7F,  // 8  abcdefg
        7'h07,  // 7  abc
        7'h7D,  // 6  acdefg
        7'h6D,  // 5  acdfg
        7'h66,  // 4  bcfg
        7'h4F,  // 3  abcdg
        7'h5B,  // 2  abdeg
        7'h06,  // 1  bc
        7'h3F   // 0  abcdef
    };

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational lookup from a lit-segment set to a hex nibble; any pattern not
// in the table (including all-off) yields nibble 0 with err set.
module sseg_pattern_decode
    import sseg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// Recovers the four displayed hex digits from a multiplexed common-anode drive.
// Define SSEG_CAPTURE_DP_EN to also capture the decimal points into dp_out.
module sseg_capture
    import sseg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [3:0]       an_q, an_p;
    logic [7:0]       sseg_cmp, sseg_q, sseg_p;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             selecting, capture, publish;
    logic [1:0]       sel_idx;
    logic [3:0]       cap_mask, seen, shadow_err;
    logic [15:0]      shadow_val;
    logic [6:0]       seg_on;
    logic [3:0]       nibble;
    logic             err;

`ifdef SSEG_CAPTURE_DP_EN
    assign sseg_cmp = sseg;
`else
    // Decimal point is forced off so it never disturbs the stability compare
    logic unused_dp;
    assign unused_dp = sseg[SEG_DP];
    assign sseg_cmp  = {1'b1, sseg[6:0]};
`endif

    // Exactly one low anode selects a digit; anything else is blanking
    always_comb begin
        selecting = 1'b1;
        sel_idx   = 2'd0;
        case (an_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: selecting = 1'b0;
        endcase
    end

    always_comb begin
        cnt_next = cnt;
        if (!selecting)
            cnt_next = '0;
        else if ({an_q, sseg_q} != {an_p, sseg_p})
            cnt_next = CNT_W'(1);
        else if (cnt < CNT_MAX)
            cnt_next = cnt + CNT_W'(1);
        capture  = selecting && (cnt_next == CNT_MAX) && (cnt != CNT_MAX);
        cap_mask = capture ? (4'b0001 << sel_idx) : 4'b0000;
        publish  = (seen == 4'b1111);
    end

    assign seg_on = ~sseg_q[6:0];

    sseg_pattern_decode u_decode (
        .seg    (seg_on),
        .nibble (nibble),
        .err    (err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q        <= 4'b1111;
            sseg_q      <= '0;
            an_p        <= 4'b1111;
            sseg_p      <= '0;
            cnt         <= '0;
            shadow_val  <= '0;
            shadow_err  <= '0;
            seen        <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            an_q        <= an;
            sseg_q      <= sseg_cmp;
            an_p        <= an_q;
            sseg_p      <= sseg_q;
            cnt         <= cnt_next;
            frame_valid <= publish;
            // A capture landing on the publish edge starts the next frame
            seen        <= (publish ? 4'b0000 : seen) | cap_mask;
            if (publish) begin
                value     <= shadow_val;
                digit_err <= shadow_err;
            end
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    shadow_val[4*i +: 4] <= nibble;
                    shadow_err[i]        <= err;
                end
            end
        end
    end

`ifdef SSEG_CAPTURE_DP_EN
    logic [3:0] shadow_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_dp <= '0;
            dp_out    <= '0;
        end else begin
            if (publish)
                dp_out <= shadow_dp;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i])
                    shadow_dp[i] <= ~sseg_q[SEG_DP];
            end
        end
    end
`else
    assign dp_out = 4'b0000;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Randomised and directed checks of sseg_capture against a run-length
// reference model of the multiplexed display.
module tb_sseg_capture;

    localparam int unsigned STABLE = 4;
`ifdef SSEG_CAPTURE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    sseg_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .sseg        (sseg),
        .value       (value),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Common-anode drive codes (active-low, dp excluded) for digits 0..F
    logic [6:0] code_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [3:0]  m_val [4];
    bit          m_err [4];
    bit          m_dp  [4];
    bit   [3:0]  m_seen;
    logic [15:0] e_value;
    logic [3:0]  e_dp, e_err;
    bit          e_fv;
    int          run;
    bit          prev_sel;
    logic [11:0] prev_key;
    bit          pend;
    int          pend_digit;
    logic [7:0]  pend_sseg;
    int          fv_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_digit(input logic [3:0] a);
        int z = 0;
        int d = -1;
        for (int k = 0; k < 4; k++) begin
            if (!a[k]) begin
                z++;
                d = k;
            end
        end
        return (z == 1) ? d : -1;
    endfunction

    task automatic ref_decode(input logic [7:0] s, output logic [3:0] n, output bit e);
        n = 4'h0;
        e = 1'b1;
        for (int d = 0; d < 16; d++) begin
            if (s[6:0] == code_lo[d]) begin
                n = 4'(d);
                e = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            m_val[k] = 4'h0;
            m_err[k] = 1'b0;
            m_dp[k]  = 1'b0;
        end
        m_seen   = '0;
        e_value  = '0;
        e_dp     = '0;
        e_err    = '0;
        e_fv     = 1'b0;
        run      = 0;
        prev_sel = 1'b0;
        prev_key = '0;
        pend     = 1'b0;
    endtask

    // One clock: check what the last edge produced, drive the next sample,
    // and predict what the following edge must produce.
    task automatic cycle(input logic [3:0] a, input logic [7:0] s);
        logic [11:0] key;
        logic [3:0]  n;
        bit          e;
        int          d;
        @(negedge clk);
        check_eq("frame_valid", 32'(frame_valid), 32'(e_fv));
        check_eq("value", 32'(value), 32'(e_value));
        check_eq("digit_err", 32'(digit_err), 32'(e_err));
        check_eq("dp_out", 32'(dp_out), 32'(e_dp));
        if (frame_valid) fv_seen++;
        an   = a;
        sseg = s;
        e_fv = (m_seen == 4'b1111);
        if (e_fv) begin
            for (int k = 0; k < 4; k++) begin
                e_value[4*k +: 4] = m_val[k];
                e_err[k]          = m_err[k];
                e_dp[k]           = m_dp[k];
            end
            m_seen = '0;
        end
        if (pend) begin
            ref_decode(pend_sseg, n, e);
            m_val[pend_digit]  = n;
            m_err[pend_digit]  = e;
            m_dp[pend_digit]   = DP_EN & ~pend_sseg[7];
            m_seen[pend_digit] = 1'b1;
        end
        d   = sel_digit(a);
        key = {a, DP_EN ? s : {1'b0, s[6:0]}};
        if (d < 0)
            run = 0;
        else if (prev_sel && key == prev_key)
            run++;
        else
            run = 1;
        prev_sel   = (d >= 0);
        prev_key   = key;
        pend       = (d >= 0) && (run == STABLE);
        pend_digit = d;
        pend_sseg  = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        an    = 4'hF;
        sseg  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_value", 32'(value), 32'h0);
        check_eq("rst_frame_valid", 32'(frame_valid), 32'h0);
        check_eq("rst_digit_err", 32'(digit_err), 32'h0);
        check_eq("rst_dp_out", 32'(dp_out), 32'h0);
        model_clear();
        reset = 1'b0;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        repeat (n) cycle(a, s);
    endtask

    // Byte k of frm is shown on digit k, each held STABLE cycles, then blanked
    task automatic run_frame(input logic [31:0] frm);
        for (int k = 0; k < 4; k++)
            hold(~(4'b0001 << k), frm[8*k +: 8], STABLE);
        hold(4'hF, 8'hFF, 4);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] s;
        int         r;
        int         len;

        model_clear();
        fv_seen = 0;
        do_reset();

        // Basic frame 0,1,2,3
        fv_seen = 0;
        run_frame({8'hB0, 8'hA4, 8'hF9, 8'hC0});
        check_eq("basic_pulses", 32'(fv_seen), 32'd1);
        check_eq("basic_value", 32'(value), 32'h3210);
        check_eq("basic_err", 32'(digit_err), 32'h0);

        // One cycle short of stable, then blank: digit 0 must stay missing
        fv_seen = 0;
        hold(4'b1110, 8'h92, STABLE - 1);
        hold(4'hF, 8'hFF, 2);
        hold(4'b1101, 8'hF9, STABLE);
        hold(4'b1011, 8'hA4, STABLE);
        hold(4'b0111, 8'hB0, STABLE);
        hold(4'hF, 8'hFF, 4);
        check_eq("short_no_frame", 32'(fv_seen), 32'd0);
        hold(4'b1110, 8'h92, STABLE);
        hold(4'hF, 8'hFF, 4);
        check_eq("short_then_full_pulses", 32'(fv_seen), 32'd1);
        check_eq("short_then_full_value", 32'(value), 32'h3215);

        // All-off digit 2 is undecodable
        run_frame({8'hB0, 8'hFF, 8'hF9, 8'hC0});
        check_eq("alloff_value", 32'(value), 32'h3010);
        check_eq("alloff_err", 32'(digit_err), 32'b0100);

        // Two anodes low never captures
        fv_seen = 0;
        hold(4'b1100, 8'hC0, 10);
        hold(4'hF, 8'hFF, 4);
        check_eq("multi_anode_pulses", 32'(fv_seen), 32'd0);

        // Partial frame discarded by reset
        hold(4'b1110, 8'hC0, STABLE);
        hold(4'b1101, 8'hF9, STABLE);
        do_reset();
        fv_seen = 0;
        run_frame({8'h80, 8'h80, 8'h80, 8'h80});
        check_eq("after_reset_pulses", 32'(fv_seen), 32'd1);
        check_eq("after_reset_value", 32'(value), 32'h8888);

        // Decimal point on digit 0
        run_frame({8'hB0, 8'hA4, 8'hF9, 8'h40});
        check_eq("dp_value_lo", 32'(value[3:0]), 32'h0);
        check_eq("dp_out", 32'(dp_out), DP_EN ? 32'b0001 : 32'b0000);

        // Random multiplexing traffic
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)
                a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7)
                a = 4'hF;
            else
                a = 4'($urandom);
            if ($urandom_range(0, 4) == 0)
                s = 8'($urandom);
            else
                s = {1'($urandom), code_lo[$urandom_range(0, 15)]};
            len = int'($urandom_range(1, STABLE + 3));
            hold(a, s, len);
            if ($urandom_range(0, 60) == 0)
                do_reset();
        end
        hold(4'hF, 8'hFF, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
